key_capture: RTL
================

Name: key_capture

Overview:
- Receiving end of the pushbutton key-event path. It consumes the scrambled 4-bit key code and key strobe driven by the pushbutton encoder/scrambler stage.
- Synchronizes and debounces the strobe, then emits exactly one event per physical press.
- Unscrambles the code with the inverse key permutation.
- Shifts each accepted digit into an 8-digit entry register that feeds the seven-segment display path.

Parameters:
DEBOUNCE, 4, consecutive synchronized samples of the same strobe level required to accept a press or a release; legal range 1..255
DIGITS, 8, nibbles held in the entry register

Ports:
hz100  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
code  input  4  scrambled key code, qualified by strobe; asynchronous to hz100
strobe  input  1  high while any key is down; asynchronous to hz100
clr  input  1  synchronous clear of the entry register and count
key_valid  output  1  one-cycle pulse per accepted press
key_code  output  4  unscrambled code of the last accepted press
held  output  1  high from acceptance until the release is accepted
digits  output  4*DIGITS  entry register; newest digit in [3:0]
count  output  $clog2(DIGITS+1)  number of valid digits, saturating at DIGITS

Behaviour:
- Reset (reset_n low, any time, takes effect immediately): all outputs 0, synchronizers 0, state IDLE, debounce counter 0.
- Synchronization: code and strobe each pass through a 2-flop synchronizer. All logic below uses the synchronized values (strobe_s, code_s).
- States:
  - IDLE: on strobe_s=1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT:
    - strobe_s=0: go to IDLE, cnt=0.
    - strobe_s=1 and cnt<DEBOUNCE: cnt++.
    - When cnt reaches DEBOUNCE: go to HELD, capture code_s, assert key_valid for one cycle.
  - HELD: strobe_s=0 goes to RELEASE_WAIT with cnt=1. Code changes while held are ignored, so no second event.
  - RELEASE_WAIT:
    - strobe_s=1: return to HELD, cnt=0.
    - strobe_s=0 for DEBOUNCE consecutive samples: go to IDLE.
- Latency: with strobe rising and staying high, key_valid is high in the cycle after clock edge DEBOUNCE+3, counted from the first edge that samples strobe high. key_code and digits update on that same edge.
- held: 1 in HELD and RELEASE_WAIT, else 0.
- Inverse permutation, applied to code_s at acceptance (in->out, hex): 0->6 1->4 2->8 3->1 4->b 5->a 6->e 7->2 8->3 9->c a->d b->0 c->f d->7 e->9 f->5.
- key_code holds its value until the next accepted press.
- Entry register: on each accept, digits <= {digits[4*DIGITS-5:0], key_code_new}. count increments and saturates at DIGITS. Shifting continues past saturation; the oldest digit is dropped.
- clr (synchronous): digits=0 and count=0 next cycle. It does not affect the FSM, key_code or held.
- clr in the same cycle as an accept: clr wins for digits/count, which end at 0. key_valid still pulses and key_code still updates.
- Strobe shorter than DEBOUNCE samples produces no event and no state change visible at the outputs.
- Reset mid-press: after reset_n releases with strobe still high, the FSM restarts from IDLE. The held key produces one fresh event after the full latency.

Decomposition:
- Shared package key_pkg holds:
  - state enum key_state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT};
  - constant KEY_INV_MAP (16 x 4-bit inverse table above);
  - function key_unmap(code).
- One sub-module, key_debounce: synchronizer, FSM and counter; outputs accept pulse and held.
- key_capture instantiates key_debounce, then applies key_unmap, the entry register and the count.

Test Plan:
- Reset check: reset_n low with strobe=1, code=4'h3 -> all outputs 0. Release reset and hold -> one key_valid, key_code=4'h1, digits=0x00000001, count=1.
- Glitch rejection: DEBOUNCE=4, strobe high for 3 cycles then low -> no key_valid, held stays 0, digits unchanged.
- Latency and held: strobe held high -> key_valid pulses exactly once after edge 7, held=1. Bounce low 2 cycles while held -> no new event. Low 4+ cycles -> held=0.
- Sequence and saturation: press codes b,3,7,8,1,f,0,d,2 (9 presses) -> count=8, digits=0x12345678 (leading 0 shifted out).
- Simultaneous clr and accept: code=4'h0 accepted in the clr cycle -> key_valid=1, key_code=6, digits=0, count=0.
- Async reset mid-operation: reset_n pulsed low while in HELD -> outputs cleared immediately, no spurious key_valid on deassert until the full debounce completes.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and the inverse key permutation for the pushbutton capture path.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } key_state_t;

    // Packed so that index N of the table is the plain code for scrambled code N.
    localparam logic [15:0][3:0] KEY_INV_MAP = {
        4'h5, 4'h9, 4'h7, 4'hf,   // f e d c
        4'h0, 4'hd, 4'hc, 4'h3,   // b a 9 8
        4'h2, 4'he, 4'ha, 4'hb,   // 7 6 5 4
        4'h1, 4'h8, 4'h4, 4'h6    // 3 2 1 0
    };

    function automatic logic [3:0] key_unmap(input logic [3:0] code);
        return KEY_INV_MAP[code];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes the key strobe/code and debounces the strobe into one accept per press.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       strobe_i,
    input  logic [3:0] code_i,
    output logic [3:0] code_s_o,
    output logic       accept_o,
    output logic       held_o
);

    localparam logic [7:0] DEB = 8'(DEBOUNCE);

    logic       strobe_meta_q, strobe_s_q;
    logic [3:0] code_meta_q, code_s_q;
    key_state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_meta_q <= 1'b0;
            strobe_s_q    <= 1'b0;
            code_meta_q   <= 4'h0;
            code_s_q      <= 4'h0;
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
        end else begin
            strobe_meta_q <= strobe_i;
            strobe_s_q    <= strobe_meta_q;
            code_meta_q   <= code_i;
            code_s_q      <= code_meta_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
        end
    end

    // A full count of samples completes the wait before the current level is looked at.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe_s_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = 8'd1;
                end
            end
            PRESS_WAIT: begin
                if (cnt_q >= DEB) begin
                    state_d  = HELD;
                    cnt_d    = 8'd0;
                    accept_o = 1'b1;
                end else if (!strobe_s_q) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HELD: begin
                if (!strobe_s_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = 8'd1;
                end
            end
            RELEASE_WAIT: begin
                if (cnt_q >= DEB) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (strobe_s_q) begin
                    state_d = HELD;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    assign code_s_o = code_s_q;
    assign held_o   = (state_q == HELD) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/key_capture.sv
// Receives scrambled key events, unscrambles them and shifts digits into the entry register.
module key_capture
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned DIGITS   = 8,
    localparam int unsigned CW      = $clog2(DIGITS + 1)
) (
    input  logic                  hz100,
    input  logic                  reset_n,
    input  logic [3:0]            code,
    input  logic                  strobe,
    input  logic                  clr,
    output logic                  key_valid,
    output logic [3:0]            key_code,
    output logic                  held,
    output logic [4*DIGITS-1:0]   digits,
    output logic [CW-1:0]         count
);

    logic [3:0] code_s;
    logic       accept;
    logic [3:0] plain;

    logic                key_valid_q;
    logic [3:0]          key_code_q, key_code_d;
    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic [CW-1:0]       count_q, count_d;

    key_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
        .clk      (hz100),
        .rst_n    (reset_n),
        .strobe_i (strobe),
        .code_i   (code),
        .code_s_o (code_s),
        .accept_o (accept),
        .held_o   (held)
    );

    assign plain = key_unmap(code_s);

    // clr overrides the shift for the entry register but never the key code itself.
    always_comb begin
        key_code_d = key_code_q;
        digits_d   = digits_q;
        count_d    = count_q;
        if (accept) begin
            key_code_d = plain;
            digits_d   = {digits_q[4*DIGITS-5:0], plain};
            if (count_q != CW'(DIGITS))
                count_d = count_q + CW'(1);
        end
        if (clr) begin
            digits_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge hz100 or negedge reset_n) begin
        if (!reset_n) begin
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            digits_q    <= '0;
            count_q     <= '0;
        end else begin
            key_valid_q <= accept;
            key_code_q  <= key_code_d;
            digits_q    <= digits_d;
            count_q     <= count_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign digits    = digits_q;
    assign count     = count_q;

endmodule
